// File: rtl/stage_pkg.sv
// Shared types and constants for the stage controller and the monsters block.
package stage_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INTRO,
    ST_PLAY,
    ST_CLEAR,
    ST_WIN,
    ST_OVER
  } state_t;

  typedef logic [2:0] stage_num_t;
  typedef logic [7:0] frame_cnt_t;

  localparam stage_num_t STAGE_IDLE    = 3'd0;
  localparam stage_num_t STAGE_FIRST   = 3'd1;
  localparam frame_cnt_t FRAME_CNT_MAX = 8'd255;

endpackage

// File: rtl/frame_counter.sv
// 8-bit saturating startOfFrame counter with clear and a terminal-count flag.
module frame_counter
  import stage_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic       i_clear,
  input  logic       i_sof,
  input  logic [7:0] i_terminal,
  output logic [7:0] o_count,
  output logic       o_done
);

  frame_cnt_t r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (i_clear) begin
      // A frame pulse landing on the clear belongs to the new state.
      r_count <= i_sof ? 8'd1 : 8'd0;
    end else if (i_sof && (r_count != FRAME_CNT_MAX)) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Done on the pulse that brings the count up to (or past) the terminal value.
  assign o_done  = i_sof && (({1'b0, r_count} + 9'd1) >= {1'b0, i_terminal});
  assign o_count = r_count;

endmodule

// File: rtl/stage_controller.sv
// Game stage sequencer: IDLE -> INTRO -> PLAY -> CLEAR ... -> WIN / OVER.
// Optional pause support is built only when STAGE_CTRL_PAUSE_EN is defined.
module stage_controller
  import stage_pkg::*;
#(
  parameter int INTRO_FRAMES   = 60,
  parameter int CLEAR_FRAMES   = 90,
  parameter int NORMAL_STAGES  = 2,
  parameter int BOSS_STAGE_NUM = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       start_game,
  input  logic       all_monsters_dead,
  input  logic       player_dead,
  input  logic       pause,
  output logic [2:0] stage_num,
  output logic       monsters_enable,
  output logic       monsters_resetN,
  output logic       stage_intro,
  output logic       stage_clear_pulse,
  output logic       game_won,
  output logic       game_over
);

  state_t     r_state, w_next_state;
  stage_num_t r_stage_num, w_next_stage;
  logic       r_monsters_resetN, r_clear_pulse, r_game_won, r_game_over, r_first_play;
  logic       w_hold, w_sof, w_frames_done, w_state_change;
  logic [7:0] w_terminal, w_unused_count;

`ifdef STAGE_CTRL_PAUSE_EN
  assign w_hold = pause && (r_state inside {ST_INTRO, ST_PLAY, ST_CLEAR});
`else
  logic w_unused_pause;
  assign w_unused_pause = pause;
  assign w_hold         = 1'b0;
`endif

  assign w_sof          = startOfFrame && !w_hold;
  assign w_terminal     = (r_state == ST_CLEAR) ? 8'(CLEAR_FRAMES) : 8'(INTRO_FRAMES);
  assign w_state_change = (w_next_state != r_state);

  frame_counter u_frame_counter (
    .clk        (clk),
    .resetN     (resetN),
    .i_clear    (w_state_change),
    .i_sof      (w_sof),
    .i_terminal (w_terminal),
    .o_count    (w_unused_count),
    .o_done     (w_frames_done)
  );

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_next_stage = r_stage_num;
    case (r_state)
      ST_IDLE, ST_WIN, ST_OVER: begin
        if (start_game) begin
          w_next_state = ST_INTRO;
          w_next_stage = STAGE_FIRST;
        end
      end
      ST_INTRO: begin
        if (w_frames_done) w_next_state = ST_PLAY;
      end
      ST_PLAY: begin
        // Death outranks clearing; the first PLAY cycle lets the monsters block settle.
        if (!w_hold) begin
          if (player_dead)                             w_next_state = ST_OVER;
          else if (all_monsters_dead && !r_first_play) w_next_state = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (w_frames_done) begin
          if (r_stage_num == stage_num_t'(BOSS_STAGE_NUM)) begin
            w_next_state = ST_WIN;
          end else if (r_stage_num < stage_num_t'(NORMAL_STAGES)) begin
            w_next_state = ST_INTRO;
            w_next_stage = r_stage_num + 3'd1;
          end else begin
            w_next_state = ST_INTRO;
            w_next_stage = stage_num_t'(BOSS_STAGE_NUM);
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_stage = STAGE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state           <= ST_IDLE;
      r_stage_num       <= STAGE_IDLE;
      r_monsters_resetN <= 1'b0;
      r_clear_pulse     <= 1'b0;
      r_game_won        <= 1'b0;
      r_game_over       <= 1'b0;
      r_first_play      <= 1'b0;
    end else begin
      r_state           <= w_next_state;
      r_stage_num       <= w_next_stage;
      r_monsters_resetN <= !((w_next_state == ST_INTRO) && (r_state != ST_INTRO));
      r_clear_pulse     <= (r_state == ST_PLAY) && (w_next_state == ST_CLEAR);
      r_game_won        <= (w_next_state == ST_WIN);
      r_game_over       <= (w_next_state == ST_OVER);
      if ((w_next_state == ST_PLAY) && (r_state != ST_PLAY)) r_first_play <= 1'b1;
      else if (!w_hold)                                      r_first_play <= 1'b0;
    end
  end

  assign stage_num         = r_stage_num;
  assign monsters_enable   = (r_state == ST_PLAY) && !w_hold;
  assign monsters_resetN   = r_monsters_resetN;
  assign stage_intro       = (r_state == ST_INTRO);
  assign stage_clear_pulse = r_clear_pulse;
  assign game_won          = r_game_won;
  assign game_over         = r_game_over;

endmodule

// File: tb/tb_stage_controller.sv
// Directed vector table plus randomized run against a frame/stage-list reference model.
module tb_stage_controller;

  localparam int INTRO_F  = 3;
  localparam int CLEAR_F  = 2;
  localparam int N_NORMAL = 2;
  localparam int BOSS     = 4;

  localparam int P_IDLE = 0, P_INTRO = 1, P_PLAY = 2, P_CLEAR = 3, P_WIN = 4, P_OVER = 5;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0, start_game = 1'b0, all_monsters_dead = 1'b0;
  logic       player_dead = 1'b0, pause = 1'b0;
  logic [2:0] stage_num;
  logic       monsters_enable, monsters_resetN, stage_intro, stage_clear_pulse, game_won, game_over;
  logic [8:0] outs;

  stage_controller #(
    .INTRO_FRAMES   (INTRO_F),
    .CLEAR_FRAMES   (CLEAR_F),
    .NORMAL_STAGES  (N_NORMAL),
    .BOSS_STAGE_NUM (BOSS)
  ) dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame      (startOfFrame),
    .start_game        (start_game),
    .all_monsters_dead (all_monsters_dead),
    .player_dead       (player_dead),
    .pause             (pause),
    .stage_num         (stage_num),
    .monsters_enable   (monsters_enable),
    .monsters_resetN   (monsters_resetN),
    .stage_intro       (stage_intro),
    .stage_clear_pulse (stage_clear_pulse),
    .game_won          (game_won),
    .game_over         (game_over)
  );

  always #5 clk = ~clk;

  // {stage[2:0], enable, monsters_resetN, intro, clear_pulse, won, over}
  assign outs = {stage_num, monsters_enable, monsters_resetN, stage_intro,
                 stage_clear_pulse, game_won, game_over};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Inputs {sof, start, amd, pd} applied at negedge, outputs sampled 1 time unit after posedge.
  task automatic apply(input logic [3:0] in);
    @(negedge clk);
    {startOfFrame, start_game, all_monsters_dead, player_dead} = in;
    @(posedge clk);
    #1;
  endtask

  // Reference model: phase, position in the stage list, frames seen in the current phase.
  int stage_seq[N_NORMAL+1];
  int m_phase, m_idx, m_frames, m_age;
  bit m_mres, m_clr;

  task automatic model_reset();
    m_phase = P_IDLE; m_idx = -1; m_frames = 0; m_age = 0; m_mres = 1'b0; m_clr = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] in);
    bit sof, start, amd, pd;
    int nxt, nidx;
    {sof, start, amd, pd} = in;
    nxt = m_phase; nidx = m_idx;
    case (m_phase)
      P_IDLE, P_WIN, P_OVER: if (start) begin nxt = P_INTRO; nidx = 0; end
      P_INTRO: if (sof && m_frames + 1 >= INTRO_F) nxt = P_PLAY;
      P_PLAY:  if (pd) nxt = P_OVER; else if (amd && m_age > 0) nxt = P_CLEAR;
      P_CLEAR: if (sof && m_frames + 1 >= CLEAR_F) begin
        if (m_idx == N_NORMAL) nxt = P_WIN;
        else begin nxt = P_INTRO; nidx = m_idx + 1; end
      end
      default: nxt = P_IDLE;
    endcase
    m_mres = !(nxt == P_INTRO && m_phase != P_INTRO);
    m_clr  = (m_phase == P_PLAY && nxt == P_CLEAR);
    if (nxt != m_phase) begin m_frames = int'(sof); m_age = 0; end
    else begin m_frames += int'(sof); m_age++; end
    m_phase = nxt; m_idx = nidx;
  endtask

  function automatic logic [8:0] model_outs();
    logic [2:0] s;
    s = (m_idx < 0) ? 3'd0 : 3'(stage_seq[m_idx]);
    return {s, (m_phase == P_PLAY), m_mres, (m_phase == P_INTRO), m_clr,
            (m_phase == P_WIN), (m_phase == P_OVER)};
  endfunction

  typedef struct packed {
    logic [3:0] in;
    logic [8:0] exp;
  } vec_t;

  vec_t dir[34];

  task automatic random_run(input int n);
    logic [3:0] in;
    for (int i = 0; i < n; i++) begin
      in = {($urandom_range(3) == 0), ($urandom_range(29) == 0),
            ($urandom_range(4) == 0), ($urandom_range(59) == 0)};
      apply(in);
      model_step(in);
      check($sformatf("rand[%0d]", i), outs, model_outs());
    end
  endtask

  initial begin
    for (int i = 0; i < N_NORMAL; i++) stage_seq[i] = i + 1;
    stage_seq[N_NORMAL] = BOSS;

    dir = '{
      '{4'b0000, 9'b000_0_1_0_0_0_0},  // reset released: monsters_resetN rises
      '{4'b0100, 9'b001_0_0_1_0_0_0},  // start -> INTRO stage 1, resetN pulse
      '{4'b0000, 9'b001_0_1_1_0_0_0},
      '{4'b1000, 9'b001_0_1_1_0_0_0},
      '{4'b1000, 9'b001_0_1_1_0_0_0},
      '{4'b0100, 9'b001_0_1_1_0_0_0},  // start ignored in INTRO
      '{4'b1000, 9'b001_1_1_0_0_0_0},  // third frame -> PLAY
      '{4'b0010, 9'b001_1_1_0_0_0_0},  // amd ignored on first PLAY clk
      '{4'b0010, 9'b001_0_1_0_1_0_0},  // -> CLEAR with pulse
      '{4'b0000, 9'b001_0_1_0_0_0_0},
      '{4'b1000, 9'b001_0_1_0_0_0_0},
      '{4'b1000, 9'b010_0_0_1_0_0_0},  // -> INTRO stage 2
      '{4'b1000, 9'b010_0_1_1_0_0_0},
      '{4'b1000, 9'b010_1_1_0_0_0_0},  // entry frame counted: PLAY after 2 more
      '{4'b0000, 9'b010_1_1_0_0_0_0},
      '{4'b0010, 9'b010_0_1_0_1_0_0},
      '{4'b1000, 9'b010_0_1_0_0_0_0},
      '{4'b1000, 9'b100_0_0_1_0_0_0},  // -> boss INTRO
      '{4'b1000, 9'b100_0_1_1_0_0_0},
      '{4'b1000, 9'b100_1_1_0_0_0_0},
      '{4'b0100, 9'b100_1_1_0_0_0_0},  // start ignored in PLAY
      '{4'b0010, 9'b100_0_1_0_1_0_0},
      '{4'b1000, 9'b100_0_1_0_0_0_0},
      '{4'b1000, 9'b100_0_1_0_0_1_0},  // -> WIN, stage held at 4
      '{4'b0000, 9'b100_0_1_0_0_1_0},
      '{4'b0100, 9'b001_0_0_1_0_0_0},  // WIN + start -> INTRO stage 1
      '{4'b1000, 9'b001_0_1_1_0_0_0},
      '{4'b1000, 9'b001_0_1_1_0_0_0},
      '{4'b1000, 9'b001_1_1_0_0_0_0},
      '{4'b0000, 9'b001_1_1_0_0_0_0},
      '{4'b0011, 9'b001_0_1_0_0_0_1},  // death and clear together: OVER, no pulse
      '{4'b0000, 9'b001_0_1_0_0_0_1},
      '{4'b0100, 9'b001_0_0_1_0_0_0},  // OVER + start -> INTRO, game_over drops
      '{4'b0000, 9'b001_0_1_1_0_0_0}
    };

    model_reset();
    #3;
    check("reset_values", outs, 9'b0);
    @(posedge clk); #1;
    check("reset_held", outs, 9'b0);

    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 34; i++) begin
      apply(dir[i].in);
      model_step(dir[i].in);
      check($sformatf("dir[%0d]", i), outs, dir[i].exp);
    end

    random_run(2000);

    // Asynchronous abort in mid-run.
    @(negedge clk);
    #2 resetN = 1'b0;
    #1 check("abort_async", outs, 9'b0);
    @(posedge clk); #1;
    check("abort_held", outs, 9'b0);
    @(negedge clk);
    resetN = 1'b1;
    model_reset();
    random_run(2000);

`ifdef STAGE_CTRL_PAUSE_EN
    begin
      @(negedge clk); resetN = 1'b0;
      @(negedge clk); resetN = 1'b1;
      apply(4'b0000);
      apply(4'b0100);
      apply(4'b1000);
      check("pause_intro_f1", outs, 9'b001_0_1_1_0_0_0);
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
        apply(4'b1000);
        check($sformatf("pause_intro[%0d]", i), outs, 9'b001_0_1_1_0_0_0);
      end
      pause = 1'b0;
      apply(4'b1000);
      check("pause_resume_f2", outs, 9'b001_0_1_1_0_0_0);
      apply(4'b1000);
      check("pause_resume_play", outs, 9'b001_1_1_0_0_0_0);
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
        apply(4'b0011);
        check($sformatf("pause_play[%0d]", i), outs, 9'b001_0_1_0_0_0_0);
      end
      pause = 1'b0;
      apply(4'b0010);
      check("pause_first_play", outs, 9'b001_1_1_0_0_0_0);
      apply(4'b0010);
      check("pause_then_clear", outs, 9'b001_0_1_0_1_0_0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
